om_tile_mem_responder: RTL



---
 rtl/VX_om_pkg.sv | 23 ++
 rtl/om_tile_rsp_queue.sv | 56 +++++
 rtl/om_tile_mem_responder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/VX_om_pkg.sv
// Shared types and constants for the OM tile memory responder.
package VX_om_pkg;

    localparam int unsigned OM_TILE_WORD_BYTES = 4;
    localparam int unsigned OM_TILE_WORD_BITS  = 8 * OM_TILE_WORD_BYTES;
    localparam int unsigned OM_PERF_WIDTH      = 32;
    localparam int unsigned OM_RSP_TAG_WIDTH   = 8;

    // Default response entry; the responder builds its own with its TAG_WIDTH.
    typedef struct packed {
        logic [OM_TILE_WORD_BITS-1:0] data;
        logic [OM_RSP_TAG_WIDTH-1:0]  tag;
    } om_rsp_t;

    // Saturating increment for the perf counters.
    function automatic logic [OM_PERF_WIDTH-1:0] om_perf_inc(
        input logic [OM_PERF_WIDTH-1:0] value,
        input logic                     en
    );
        return (en && (value != '1)) ? value + OM_PERF_WIDTH'(1) : value;
    endfunction

endpackage

// File: rtl/om_tile_rsp_queue.sv
// Synchronous response FIFO with occupancy count and asynchronous reset.
// Push while full and pop while empty are ignored.
module om_tile_rsp_queue
    import VX_om_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type rsp_t = om_rsp_t,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  rsp_t             push_data,
    input  logic             pop,
    output rsp_t             pop_data,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    rsp_t             store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = store[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/om_tile_mem_responder.sv
// OM tile memory responder: services OCACHE-style word requests from a local
// tile SRAM and returns read responses in order with the tag echoed.
// Optional macro: OM_TILE_MEM_WRITE_ACK_EN - writes also return a response
// (data 0) and consume a response credit.
module om_tile_mem_responder
    import VX_om_pkg::*;
#(
    parameter int unsigned           WORDS          = 1024,
    parameter int unsigned           ADDR_WIDTH     = 26,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int unsigned           TAG_WIDTH      = 8,
    parameter int unsigned           RSP_QUEUE_SIZE = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_rw,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [3:0]            req_byteen,
    input  logic [31:0]           req_data,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_data,
    output logic [TAG_WIDTH-1:0]  rsp_tag,
    input  logic                  rsp_ready,
    output logic [31:0]           perf_reads,
    output logic [31:0]           perf_writes,
    output logic [31:0]           perf_oob
);

    localparam int unsigned IDX_W = $clog2(WORDS);
    localparam int unsigned CNT_W = $clog2(RSP_QUEUE_SIZE) + 1;

    typedef struct packed {
        logic [OM_TILE_WORD_BITS-1:0] data;
        logic [TAG_WIDTH-1:0]         tag;
    } tile_rsp_t;

    logic [OM_TILE_WORD_BITS-1:0] sram [WORDS];

    logic                  ready_en;
    logic [ADDR_WIDTH-1:0] addr_off;
    logic                  in_range;
    logic [IDX_W-1:0]      idx;
    logic                  accept;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  s1_load;
    logic                  s1_valid;
    tile_rsp_t             s1_rsp;
    tile_rsp_t             q_head;
    logic                  q_empty;
    logic                  q_full;
    logic [CNT_W-1:0]      q_count;
    logic [CNT_W-1:0]      credits;
    logic                  has_credit;

    // Offset is taken modulo 2^ADDR_WIDTH so addresses below BASE_ADDR wrap
    // to large values and decode as out of range.
    assign addr_off   = req_addr - BASE_ADDR;
    assign in_range   = addr_off < ADDR_WIDTH'(WORDS);
    assign idx        = addr_off[IDX_W-1:0];

    // Every response-producing request holds a credit from accept until the
    // queue pops it, so S1 plus the queue can never exceed the queue depth.
    assign credits    = CNT_W'(RSP_QUEUE_SIZE) - (q_count + CNT_W'(s1_valid));
    assign has_credit = (credits != '0);

`ifdef OM_TILE_MEM_WRITE_ACK_EN
    assign req_ready  = ready_en && has_credit;
    assign s1_load    = accept;
`else
    assign req_ready  = ready_en && (has_credit || req_rw);
    assign s1_load    = rd_acc;
`endif

    assign accept     = req_valid && req_ready;
    assign rd_acc     = accept && !req_rw;
    assign wr_acc     = accept && req_rw;

    // Byte-masked SRAM write; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (wr_acc && in_range) begin
            for (int unsigned i = 0; i < OM_TILE_WORD_BYTES; i++) begin
                if (req_byteen[i]) sram[idx][i*8 +: 8] <= req_data[i*8 +: 8];
            end
        end
    end

    // Read stage S1, ready enable and perf counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_en    <= 1'b0;
            s1_valid    <= 1'b0;
            s1_rsp      <= '0;
            perf_reads  <= '0;
            perf_writes <= '0;
            perf_oob    <= '0;
        end else begin
            ready_en <= 1'b1;
            s1_valid <= s1_load;
            if (s1_load) begin
                s1_rsp.tag  <= req_tag;
                s1_rsp.data <= (rd_acc && in_range) ? sram[idx] : '0;
            end
            perf_reads  <= om_perf_inc(perf_reads, rd_acc);
            perf_writes <= om_perf_inc(perf_writes, wr_acc);
            perf_oob    <= om_perf_inc(perf_oob, accept && !in_range);
        end
    end

    om_tile_rsp_queue #(
        .DEPTH (RSP_QUEUE_SIZE),
        .rsp_t (tile_rsp_t)
    ) rsp_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (s1_valid),
        .push_data (s1_rsp),
        .pop       (rsp_ready),
        .pop_data  (q_head),
        .empty     (q_empty),
        .full      (q_full),
        .count     (q_count)
    );

    assign rsp_valid = !q_empty;
    assign rsp_data  = q_head.data;
    assign rsp_tag   = q_head.tag;

    // Credit accounting guarantees S1 never pushes into a full queue.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(s1_valid && q_full));

endmodule
